phy_tx_ctrl: RTL and testbench

PHY_TX_CTRL -- requirements
Module: phy_tx_ctrl

---
 rtl/phy_tx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_phy_tx_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_ctrl.sv
// PHY transmit controller: brings the link up with a burst of training words,
// then arbitrates two packet requesters onto a single registered word stream,
// keeping packets contiguous and alternating requesters packet by packet.
module phy_tx_ctrl #(
    parameter int          TS_COUNT  = 16,
    parameter logic [31:0] TS_WORD   = 32'hBCBC4A4A,
    parameter logic [31:0] IDLE_WORD = 32'h7C7C7C7C
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        link_up
);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        TRAIN    = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    // Index of the final training word; the counter runs 0..TS_LAST.
    localparam logic [7:0] TS_LAST = 8'(TS_COUNT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        lock_q, lock_d;       // a multi-word packet is in flight
    logic        owner_q, owner_d;     // requester that owns the lock
    logic        ptr_q, ptr_d;         // round-robin preference when both valid
    logic [31:0] data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        link_up_q, link_up_d;

    logic        rdy0, rdy1;
    logic        xfer;
    logic        xfer_idx;
    logic [31:0] xfer_data;
    logic        xfer_last;

    // Ready generation: the lock owner keeps ready exclusively; otherwise a new
    // packet may start only while enable is high, so a disable drains cleanly.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (state_q == ACTIVE && !reset) begin
            if (lock_q) begin
                if (owner_q) rdy1 = 1'b1;
                else         rdy0 = 1'b1;
            end else if (enable) begin
                if (req0_valid && req1_valid) begin
                    if (ptr_q) rdy1 = 1'b1;
                    else       rdy0 = 1'b1;
                end else if (req0_valid) begin
                    rdy0 = 1'b1;
                end else if (req1_valid) begin
                    rdy1 = 1'b1;
                end
            end
        end
    end

    assign req0_ready = rdy0;
    assign req1_ready = rdy1;

    // Select the word that actually transfers this cycle (at most one).
    always_comb begin
        xfer      = (rdy0 && req0_valid) || (rdy1 && req1_valid);
        xfer_idx  = rdy1;
        xfer_data = rdy1 ? req1_data : req0_data;
        xfer_last = rdy1 ? req1_last : req0_last;
    end

    // Next-state, lock/pointer bookkeeping and the next registered output word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        data_out_d  = 32'h0;
        valid_out_d = 1'b0;

        case (state_q)
            DISABLED: begin
                if (enable) begin
                    state_d = TRAIN;
                    cnt_d   = 8'd0;
                end
            end
            TRAIN: begin
                if (!enable) begin
                    state_d = DISABLED;
                    cnt_d   = 8'd0;
                end else begin
                    data_out_d  = TS_WORD;
                    valid_out_d = 1'b1;
                    cnt_d       = cnt_q + 8'd1;
                    if (cnt_q == TS_LAST) begin
                        state_d = ACTIVE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            ACTIVE: begin
                data_out_d  = IDLE_WORD;
                valid_out_d = 1'b1;
                if (xfer) begin
                    data_out_d = xfer_data;
                    if (xfer_last) begin
                        lock_d = 1'b0;
                        ptr_d  = ~xfer_idx;
                    end else begin
                        lock_d  = 1'b1;
                        owner_d = xfer_idx;
                    end
                end
                // Leave only once no packet is owned; an unlocked exit with no
                // final word to send goes quiet immediately.
                if (!enable) begin
                    if (!lock_q) begin
                        state_d     = DISABLED;
                        data_out_d  = 32'h0;
                        valid_out_d = 1'b0;
                    end else if (xfer && xfer_last) begin
                        state_d = DISABLED;
                    end
                end
            end
            default: begin
                state_d = DISABLED;
            end
        endcase

        link_up_d = (state_d == ACTIVE);
    end

    // State and output registers with synchronous reset overriding everything.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q     <= DISABLED;
            cnt_q       <= 8'd0;
            lock_q      <= 1'b0;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
            data_out_q  <= 32'h0;
            valid_out_q <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            link_up_q   <= link_up_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign link_up   = link_up_q;

endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Directed bench for phy_tx_ctrl with TS_COUNT=4: training, arbitration,
// lock behaviour, disable draining and reset recovery.
module tb_phy_tx_ctrl;

    localparam logic [31:0] TS   = 32'hBCBC4A4A;
    localparam logic [31:0] IDLE = 32'h7C7C7C7C;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] req0_data, req1_data;
    logic        req0_valid, req1_valid;
    logic        req0_last, req1_last;
    logic        req0_ready, req1_ready;
    logic [31:0] data_out;
    logic        valid_out;
    logic        link_up;

    int tests_run = 0;
    int tests_failed = 0;

    phy_tx_ctrl #(
        .TS_COUNT (4),
        .TS_WORD  (32'hBCBC4A4A),
        .IDLE_WORD(32'h7C7C7C7C)
    ) dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .enable    (enable),
        .req0_data (req0_data),
        .req0_valid(req0_valid),
        .req0_last (req0_last),
        .req0_ready(req0_ready),
        .req1_data (req1_data),
        .req1_valid(req1_valid),
        .req1_last (req1_last),
        .req1_ready(req1_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .link_up   (link_up)
    );

    always #5 clk_2f = ~clk_2f;

    // Advance one clock; return 1 time unit after the edge so outputs are stable.
    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic v, input logic l);
        chk({tag, ".data"}, data_out, d);
        chk({tag, ".valid"}, {31'h0, valid_out}, {31'h0, v});
        chk({tag, ".link"}, {31'h0, link_up}, {31'h0, l});
    endtask

    // Settle combinational ready after input changes, then compare both readies.
    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".rdy0"}, {31'h0, req0_ready}, {31'h0, r0});
        chk({tag, ".rdy1"}, {31'h0, req1_ready}, {31'h0, r1});
    endtask

    task automatic drive0(input logic v, input logic [31:0] d, input logic l);
        req0_valid = v; req0_data = d; req0_last = l;
    endtask

    task automatic drive1(input logic v, input logic [31:0] d, input logic l);
        req1_valid = v; req1_data = d; req1_last = l;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0;
        drive0(1'b0, 32'h0, 1'b0);
        drive1(1'b0, 32'h0, 1'b0);
        tick(); tick();
        chk_out("reset", 32'h0, 1'b0, 1'b0);
        chk_rdy("reset", 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_out("idle_disabled", 32'h0, 1'b0, 1'b0);

        // Training: one DISABLED->TRAIN edge, then exactly four TS words.
        enable = 1'b1;
        tick();
        chk_out("train_entry", 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_rdy($sformatf("train%0d", i), 1'b0, 1'b0);
            tick();
            chk_out($sformatf("train%0d", i), TS, 1'b1, (i == 3));
        end
        tick();
        chk_out("first_idle", IDLE, 1'b1, 1'b1);

        // Two 2-word packets, both requesters valid: A1,A2 then B1,B2.
        drive0(1'b1, 32'hA1, 1'b0); drive1(1'b1, 32'hB1, 1'b0);
        chk_rdy("rr_a1", 1'b1, 1'b0);
        tick(); chk_out("rr_a1", 32'hA1, 1'b1, 1'b1);
        drive0(1'b1, 32'hA2, 1'b1);
        chk_rdy("rr_a2", 1'b1, 1'b0);
        tick(); chk_out("rr_a2", 32'hA2, 1'b1, 1'b1);
        drive0(1'b1, 32'hA3, 1'b0);
        chk_rdy("rr_b1", 1'b0, 1'b1);
        tick(); chk_out("rr_b1", 32'hB1, 1'b1, 1'b1);
        drive1(1'b1, 32'hB2, 1'b1);
        chk_rdy("rr_b2", 1'b0, 1'b1);
        tick(); chk_out("rr_b2", 32'hB2, 1'b1, 1'b1);
        drive0(1'b0, 32'h0, 1'b0); drive1(1'b0, 32'h0, 1'b0);
        tick(); chk_out("rr_idle", IDLE, 1'b1, 1'b1);

        // Gap inside a locked req0 packet while req1 waits.
        drive0(1'b1, 32'hC1, 1'b0); drive1(1'b1, 32'hD1, 1'b1);
        chk_rdy("gap_c1", 1'b1, 1'b0);
        tick(); chk_out("gap_c1", 32'hC1, 1'b1, 1'b1);
        drive0(1'b0, 32'h0, 1'b0);
        chk_rdy("gap_hole", 1'b1, 1'b0);
        tick(); chk_out("gap_hole", IDLE, 1'b1, 1'b1);
        drive0(1'b1, 32'hC2, 1'b1);
        chk_rdy("gap_c2", 1'b1, 1'b0);
        tick(); chk_out("gap_c2", 32'hC2, 1'b1, 1'b1);
        drive0(1'b0, 32'h0, 1'b0);
        chk_rdy("gap_d1", 1'b0, 1'b1);
        tick(); chk_out("gap_d1", 32'hD1, 1'b1, 1'b1);
        drive1(1'b0, 32'h0, 1'b0);

        // Enable dropped during a locked req1 packet: packet drains first.
        drive1(1'b1, 32'hE1, 1'b0);
        chk_rdy("drain_e1", 1'b0, 1'b1);
        tick(); chk_out("drain_e1", 32'hE1, 1'b1, 1'b1);
        enable = 1'b0;
        drive1(1'b1, 32'hE2, 1'b0);
        chk_rdy("drain_e2", 1'b0, 1'b1);
        tick(); chk_out("drain_e2", 32'hE2, 1'b1, 1'b1);
        drive1(1'b1, 32'hE3, 1'b1);
        chk_rdy("drain_e3", 1'b0, 1'b1);
        tick(); chk_out("drain_e3", 32'hE3, 1'b1, 1'b0);
        drive1(1'b0, 32'h0, 1'b0);
        chk_rdy("drain_done", 1'b0, 1'b0);
        tick(); chk_out("drain_done", 32'h0, 1'b0, 1'b0);

        // Enable dropped at training count 1.
        enable = 1'b1;
        tick(); chk_out("abort_entry", 32'h0, 1'b0, 1'b0);
        tick(); chk_out("abort_ts0", TS, 1'b1, 1'b0);
        enable = 1'b0;
        tick(); chk_out("abort_dis", 32'h0, 1'b0, 1'b0);
        tick(); chk_out("abort_stay", 32'h0, 1'b0, 1'b0);

        // Reset at training count 2, then retraining from count 0.
        enable = 1'b1;
        tick(); tick(); tick();
        chk_out("pre_rst_train", TS, 1'b1, 1'b0);
        reset = 1'b1;
        chk_rdy("rst_train", 1'b0, 1'b0);
        tick(); chk_out("rst_train", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); chk_out("retrain_entry", 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("retrain%0d", i), TS, 1'b1, (i == 3));
        end

        // Reset in the middle of a locked req0 packet.
        drive0(1'b1, 32'hF1, 1'b0);
        chk_rdy("mid_f1", 1'b1, 1'b0);
        tick(); chk_out("mid_f1", 32'hF1, 1'b1, 1'b1);
        drive0(1'b1, 32'hF2, 1'b0);
        reset = 1'b1;
        chk_rdy("rst_mid", 1'b0, 1'b0);
        tick(); chk_out("rst_mid", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        drive0(1'b0, 32'h0, 1'b0);
        tick(); chk_out("post_rst", 32'h0, 1'b0, 1'b0);

        // After retraining the lock must be gone: a lone req1 gets ready.
        for (int i = 0; i < 4; i++) tick();
        chk_out("relink", TS, 1'b1, 1'b1);
        drive1(1'b1, 32'h11, 1'b1);
        chk_rdy("unlocked", 1'b0, 1'b1);
        tick(); chk_out("unlocked", 32'h11, 1'b1, 1'b1);
        drive1(1'b0, 32'h0, 1'b0);
        tick(); chk_out("final_idle", IDLE, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
